// File: rtl/dab_gate_deadtime.sv
// Three-level bridge commands to eight H-bridge gates, with one dead-time FSM per leg.
// Define GATE_ACTIVE_LOW_EN for active-low gate outputs (off = 1).
module dab_gate_deadtime #(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [1:0]      V1,
  input  logic [1:0]      V2,
  input  logic [DT_W-1:0] deadtime,
  output logic [3:0]      Sp,
  output logic [3:0]      Ss,
  output logic            fault
);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_DEAD = 2'd1;
  localparam logic [1:0] ST_LO   = 2'd2;
  localparam logic [1:0] ST_HI   = 2'd3;

`ifdef GATE_ACTIVE_LOW_EN
  localparam logic [7:0] GATE_POL = 8'hFF;
`else
  localparam logic [7:0] GATE_POL = 8'h00;
`endif

  logic [1:0]      state     [4];
  logic [1:0]      state_nxt [4];
  logic [DT_W-1:0] cnt       [4];
  logic [DT_W-1:0] cnt_nxt   [4];
  logic [3:0]      tgt_hi;
  logic            illegal;
  logic            fault_nxt;
  logic [7:0]      gate_nxt;

  // Leg order: primary A, primary B, secondary A, secondary B.
  always_comb begin
    illegal   = en && ((V1 == 2'b10) || (V2 == 2'b10));
    fault_nxt = fault || illegal;
    tgt_hi[0] = (V1 == 2'b01);
    tgt_hi[1] = (V1 == 2'b11);
    tgt_hi[2] = (V2 == 2'b01);
    tgt_hi[3] = (V2 == 2'b11);
    gate_nxt  = 8'h00;
    for (int i = 0; i < 4; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      if (fault_nxt || !en) begin
        state_nxt[i] = ST_OFF;
      end else begin
        case (state[i])
          ST_OFF: begin
            state_nxt[i] = ST_DEAD;
            cnt_nxt[i]   = deadtime;
          end
          ST_DEAD: begin
            // Target is looked up at exit, so a reverted command lands on the new target.
            if (cnt[i] <= DT_W'(1)) begin
              state_nxt[i] = tgt_hi[i] ? ST_HI : ST_LO;
              cnt_nxt[i]   = '0;
            end else begin
              cnt_nxt[i]   = cnt[i] - DT_W'(1);
            end
          end
          ST_LO: begin
            if (tgt_hi[i]) begin
              state_nxt[i] = ST_DEAD;
              cnt_nxt[i]   = deadtime;
            end else begin
              state_nxt[i] = ST_LO;
            end
          end
          ST_HI: begin
            if (!tgt_hi[i]) begin
              state_nxt[i] = ST_DEAD;
              cnt_nxt[i]   = deadtime;
            end else begin
              state_nxt[i] = ST_HI;
            end
          end
          default: begin
            state_nxt[i] = ST_OFF;
          end
        endcase
      end
      gate_nxt[2*i]   = (state_nxt[i] == ST_HI);
      gate_nxt[2*i+1] = (state_nxt[i] == ST_LO);
    end
  end

  // Leg state, counters, fault and output gate registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        state[i] <= ST_OFF;
        cnt[i]   <= '0;
      end
      fault     <= 1'b0;
      {Ss, Sp}  <= GATE_POL;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
      fault     <= fault_nxt;
      {Ss, Sp}  <= gate_nxt ^ GATE_POL;
    end
  end

endmodule

// File: doc/dab_gate_deadtime.md
# dab_gate_deadtime

Converts the two three-level bridge voltage commands (V1 primary, V2 secondary; values −1/0/+1) produced by the DAB phase-shift pattern generator into the eight gate signals of the primary and secondary H-bridges. Each of the four bridge legs gets its own dead-time insertion state machine, so a leg's high and low switch are never on together. The block sits between the pattern generator and the FPGA gate-driver pins and is the only path by which gate outputs change.

## Interface
- `DT_W`, 8: width of the dead-time count input; the maximum dead time is 2^DT_W−1 cycles.
- `clk`  in  1: system clock. Dead time is counted in periods of this clock.
- `rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: gate enable. While low, all switches are off.
- `V1`  in  2 (signed): primary bridge command. 2'b01 = +1, 2'b00 = 0, 2'b11 = −1, 2'b10 = illegal.
- `V2`  in  2 (signed): secondary bridge command, same coding as `V1`.
- `deadtime`  in  DT_W: dead time in clock cycles. It is sampled each time a leg enters DEAD.
- `Sp`  out  4: primary gates. [0] = S1 (leg A high), [1] = S2 (leg A low), [2] = S3 (leg B high), [3] = S4 (leg B low).
- `Ss`  out  4: secondary gates, same bit order as `Sp`.
- `fault`  out  1: sticky illegal-command flag.

## Operation
- Command to leg targets, per bridge (HI = high switch on, LO = low switch on):
  - +1 → leg A HI, leg B LO.
  - 0 → leg A LO, leg B LO.
  - −1 → leg A LO, leg B HI.
- With this mapping, any ±1↔0 transition toggles exactly one leg, and a +1↔−1 transition toggles both legs.
- Each of the four legs runs an identical FSM with states OFF, DEAD, LO, HI and an unsigned DT_W-bit down-counter.
  - **OFF**: both switches off. When `en`=1 and `fault`=0, load the counter with `deadtime` and go to DEAD.
  - **DEAD**: both switches off. Decrement the counter each cycle. When the counter is ≤1, go to the leg's current target (HI or LO). The target is re-evaluated at exit, not latched at entry.
  - **LO / HI**: only the matching switch is on. When the target differs from the current state, load the counter with `deadtime` and go to DEAD.
- DEAD lasts max(`deadtime`, 1) cycles. A `deadtime` of 0 behaves as 1.
- If the command reverts while a leg is in DEAD, the leg keeps counting and then enters the new target. The dead time is never shortened.
- If `en`=0 in any state, all four legs go to OFF on the next edge. When `en` returns to 1, every leg passes through DEAD before any switch turns on.
- Illegal code (2'b10) on `V1` or `V2`, sampled while `en`=1:
  - `fault` is set to 1.
  - All legs go to OFF.
  - Legs stay in OFF until `rst`. `fault` clears only on `rst`.
- All outputs are registered, driven directly from the leg state.

## Timing
- Reset: all legs go to OFF, the counters to 0, `Sp`=4'b0000, `Ss`=4'b0000, `fault`=0. Reset takes effect immediately (asynchronous). Release is synchronous to `clk`.
- Inputs are sampled on every rising edge of `clk`.
- Turn-off latency: a command change sampled at edge n turns off the active switch at the output after edge n.
- Turn-on latency: the new switch turns on after edge n+max(D,1), where D = `deadtime` sampled at edge n.
- When the command is held constant, the outputs are static. The block does not generate pulses of its own.
- Illegal code sampled at edge n: `fault`=1 and all gates are 0 after edge n.
- `en`, `rst`, and the command may change together. Precedence is `rst` > `fault` > `en`=0 > command.

## Configuration
- `GATE_ACTIVE_LOW_EN`:
  - Defined: `Sp` and `Ss` are inverted at the output register for active-low drivers. "Off" becomes 1, so the reset value is 4'b1111 on both buses.
  - Undefined: gates are active-high and the reset value is 4'b0000.
- The FSM, `fault`, and timing are identical in both builds.

## Test plan
- Reset, then `en`=1, `V1`=0, `deadtime`=5 → `Sp`=4'b0000 for 5 cycles, then `Sp`=4'b1010 (S2, S4 on).
- From steady `V1`=0, step `V1` to +1 with `deadtime`=5 → S2 drops after the next edge, S1 rises 5 cycles later (`Sp`=4'b1001). S3 and S4 are unchanged throughout.
- Step `V2` from +1 to −1 with `deadtime`=3 → all four `Ss` bits are 0 for 3 cycles, then `Ss`=4'b0110.
- Step `V1` from 0 to +1, then back to 0 two cycles later with `deadtime`=10 → S1 never turns on. S2 turns back on 10 cycles after it dropped, not earlier.
- Drive `V2`=2'b10 for 1 cycle with `en`=1 → `fault`=1 and all gates 0 after that edge. Outputs stay 0 with legal commands until `rst`.
- Run with `deadtime`=0 and alternating +1/−1 every 20 cycles → exactly 1 dead cycle per leg transition. Check on every cycle that no leg has its high and low bit both 1; repeat the whole run with `GATE_ACTIVE_LOW_EN` and expect inverted values.
